// File: rtl/game_classic_ctrl.sv
// game_classic_ctrl - classic-mode round sequencer.
//
// Tracks player HP from tank-death events, grants a short invulnerability
// window after each hit, optionally awards bonus HP at score milestones,
// and drives the HP LED bar, score display and game-over flag.
//
// Optional feature macro: GAME_CLASSIC_BONUS_HP_EN
//   defined   -> milestone bonus HP at 1x/2x/3x BONUS_STEP
//   undefined -> no bonus logic; HP never rises within a round
//
// Ports:
//   clk                 system clock
//   rst_n               synchronous active-low reset
//   enable_game_classic level, high while classic mode is selected
//   mytank_state        1 = player tank alive; a 1->0 fall is a hit
//   scorea..scored      per-enemy kill counts (5b each)
//   hp_value            current HP
//   seg_classic         summed score, zero-extended
//   led_classic         HP bar, filled from bit 15 downward
//   gameover_classic    high while in OVER
//   game_state          IDLE=0, PLAY=1, INVULN=2, OVER=3
module game_classic_ctrl #(
  parameter int unsigned HP_INIT       = 8,
  parameter int unsigned HP_MAX        = 8,
  parameter int unsigned INVULN_CYCLES = 50_000_000,
  parameter int unsigned BONUS_STEP    = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable_game_classic,
  input  logic        mytank_state,
  input  logic [4:0]  scorea,
  input  logic [4:0]  scoreb,
  input  logic [4:0]  scorec,
  input  logic [4:0]  scored,
  output logic [3:0]  hp_value,
  output logic [15:0] seg_classic,
  output logic [15:0] led_classic,
  output logic        gameover_classic,
  output logic [1:0]  game_state
);

  if (HP_INIT < 1 || HP_INIT > HP_MAX || HP_MAX > 15 ||
      INVULN_CYCLES < 1 || BONUS_STEP < 1) begin : g_param_check
    $error("game_classic_ctrl: illegal parameter set");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    INVULN = 2'd2,
    OVER   = 2'd3
  } state_t;

  state_t      state, state_nx;
  logic [3:0]  hp, hp_nx;
  logic [6:0]  score_sum;
  logic        mytank_d;
  logic        hit;
  logic [31:0] inv_cnt, inv_nx;
  logic        apply_bonus;
  logic        award;

  function automatic logic [3:0] sat_inc(input logic [3:0] h);
    return (h >= 4'(HP_MAX)) ? h : h + 4'd1;
  endfunction

  assign hit = mytank_d & ~mytank_state;

`ifdef GAME_CLASSIC_BONUS_HP_EN
  logic [2:0] bonus_done, bonus_nx, pending, grant;

  assign pending[0] = ({25'b0, score_sum} >= BONUS_STEP)      && !bonus_done[0];
  assign pending[1] = ({25'b0, score_sum} >= 2 * BONUS_STEP)  && !bonus_done[1];
  assign pending[2] = ({25'b0, score_sum} >= 3 * BONUS_STEP)  && !bonus_done[2];
  // Isolate the lowest pending milestone: one award per cycle.
  assign grant = pending & (~pending + 3'd1);
  assign award = |pending;
`else
  assign award = 1'b0;
`endif

  always_comb begin
    state_nx    = state;
    hp_nx       = hp;
    inv_nx      = inv_cnt;
    apply_bonus = 1'b0;
`ifdef GAME_CLASSIC_BONUS_HP_EN
    bonus_nx    = bonus_done;
`endif
    case (state)
      IDLE: begin
        hp_nx  = 4'(HP_INIT);
        inv_nx = '0;
`ifdef GAME_CLASSIC_BONUS_HP_EN
        bonus_nx = '0;
`endif
        state_nx = PLAY;
      end
      PLAY: begin
        if (hit && hp == 4'd1) begin
          // A fatal hit blocks any same-cycle award and leaves it pending.
          hp_nx    = '0;
          state_nx = OVER;
        end else if (hit) begin
          hp_nx       = hp - 4'd1;
          inv_nx      = 32'(INVULN_CYCLES - 1);
          state_nx    = INVULN;
          apply_bonus = 1'b1;
        end else begin
          apply_bonus = 1'b1;
        end
      end
      INVULN: begin
        if (inv_cnt == '0) state_nx = PLAY;
        else               inv_nx   = inv_cnt - 32'd1;
        apply_bonus = 1'b1;
      end
      default: ;
    endcase

    // Applied on top of any hit decrement, so hit+bonus nets to no change.
    if (apply_bonus && award) begin
      hp_nx = sat_inc(hp_nx);
`ifdef GAME_CLASSIC_BONUS_HP_EN
      bonus_nx = bonus_done | grant;
`endif
    end

    // Dropping out of classic mode restarts the round immediately.
    if (!enable_game_classic) begin
      state_nx = IDLE;
      hp_nx    = 4'(HP_INIT);
      inv_nx   = '0;
`ifdef GAME_CLASSIC_BONUS_HP_EN
      bonus_nx = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      hp        <= 4'(HP_INIT);
      score_sum <= '0;
      mytank_d  <= 1'b1;
      inv_cnt   <= '0;
`ifdef GAME_CLASSIC_BONUS_HP_EN
      bonus_done <= '0;
`endif
    end else begin
      state     <= state_nx;
      hp        <= hp_nx;
      score_sum <= {2'b0, scorea} + {2'b0, scoreb} + {2'b0, scorec} + {2'b0, scored};
      mytank_d  <= mytank_state;
      inv_cnt   <= inv_nx;
`ifdef GAME_CLASSIC_BONUS_HP_EN
      bonus_done <= bonus_nx;
`endif
    end
  end

  assign hp_value         = hp;
  assign seg_classic      = {9'b0, score_sum};
  assign led_classic      = ~(16'hFFFF >> hp);
  assign gameover_classic = (state == OVER);
  assign game_state       = state;

endmodule
